// File: rtl/eccdes_pkg.sv
// ---------------------------------------------------------------------------
// eccdes_pkg
// Shared definitions for the ECC/3DES host interface:
//   - register map, expressed as 8-word regions plus word offsets
//   - CTRL register bit positions
//   - control FSM state encoding
//   - selectWord(): picks one 32-bit host word out of a 164-bit operand
// ---------------------------------------------------------------------------
package eccdes_pkg;

    // The map is organised in 8-word regions; region = address >> 3.
    localparam int REGION_CTRL = 0;   // 0x00-0x07: CTRL and STATUS
    localparam int REGION_K    = 1;   // 0x08-0x0D
    localparam int REGION_PX   = 2;   // 0x10-0x15
    localparam int REGION_PY   = 3;   // 0x18-0x1D
    localparam int REGION_PUX  = 4;   // 0x20-0x25
    localparam int REGION_PUY  = 5;   // 0x28-0x2D

    localparam logic [2:0] WORD_CTRL   = 3'd0;
    localparam logic [2:0] WORD_STATUS = 3'd1;

    localparam int OPERAND_W = 164;

    // CTRL register bits
    localparam int CTRL_ECC1     = 0;
    localparam int CTRL_ECC2     = 1;
    localparam int CTRL_DES      = 2;
    localparam int CTRL_DES_STOP = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        E1_GO    = 3'd1,
        E1_WAIT  = 3'd2,
        E2_GO    = 3'd3,
        E2_WAIT  = 3'd4,
        DES_RUN  = 3'd5,
        DES_WAIT = 3'd6
    } state_t;

    // Word 5 only carries the top four bits; words 6 and 7 read as zero.
    function automatic logic [31:0] selectWord(input logic [OPERAND_W-1:0] value,
                                               input logic [2:0]           idx);
        logic [31:0] word;
        word = '0;
        case (idx)
            3'd0:    word = value[31:0];
            3'd1:    word = value[63:32];
            3'd2:    word = value[95:64];
            3'd3:    word = value[127:96];
            3'd4:    word = value[159:128];
            3'd5:    word = {28'b0, value[163:160]};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/eccdes_host_if_word_reg164.sv
// ---------------------------------------------------------------------------
// word_reg164
// One 164-bit operand register assembled from six 32-bit host writes,
// with a word-indexed readback mux.
//   clk, n_rst   : clock, asynchronous active-low reset
//   wr_en_i      : write strobe for this operand
//   wr_word_i    : word index being written (0..5, others ignored)
//   wr_data_i    : host write data (only [3:0] used for word 5)
//   rd_word_i    : word index being read
//   value_o      : full 164-bit operand
//   rd_data_o    : selected 32-bit word (zero for indices 6 and 7)
// ---------------------------------------------------------------------------
module word_reg164
    import eccdes_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 wr_en_i,
    input  logic [2:0]           wr_word_i,
    input  logic [31:0]          wr_data_i,
    input  logic [2:0]           rd_word_i,
    output logic [OPERAND_W-1:0] value_o,
    output logic [31:0]          rd_data_o
);

    logic [OPERAND_W-1:0] value_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_q <= '0;
        end else if (wr_en_i) begin
            case (wr_word_i)
                3'd0:    value_q[31:0]    <= wr_data_i;
                3'd1:    value_q[63:32]   <= wr_data_i;
                3'd2:    value_q[95:64]   <= wr_data_i;
                3'd3:    value_q[127:96]  <= wr_data_i;
                3'd4:    value_q[159:128] <= wr_data_i;
                3'd5:    value_q[163:160] <= wr_data_i[3:0];
                default: ;
            endcase
        end
    end

    assign value_o   = value_q;
    assign rd_data_o = selectWord(value_q, rd_word_i);

endmodule

// File: rtl/eccdes_host_if.sv
// ---------------------------------------------------------------------------
// eccdes_host_if
// Memory-mapped host slave for the ECCDH3DES controller. Holds the private
// scalar and point operands, exposes the public key, sequences start
// commands and reports completion through sticky status bits and irq.
//   clk, n_rst         : clock, asynchronous active-low reset
//   avs_*              : host slave port (one-cycle read latency)
//   ecc_start1/2       : one-cycle start pulses for the two ECC phases
//   des_start          : level held for the whole DES run
//   ecc1/2_done,des_done : completion flags from the controller
//   PuX, PuY           : public key, read-only to the host
//   k_out,px_out,py_out: operand registers to the ECC core
//   irq                : high while any sticky done bit is set
// ---------------------------------------------------------------------------
module eccdes_host_if
    import eccdes_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_write,
    input  logic                 avs_read,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 ecc_start1,
    output logic                 ecc_start2,
    output logic                 des_start,
    input  logic                 ecc1_done,
    input  logic                 ecc2_done,
    input  logic                 des_done,
    input  logic [OPERAND_W-1:0] PuX,
    input  logic [OPERAND_W-1:0] PuY,
    output logic [OPERAND_W-1:0] k_out,
    output logic [OPERAND_W-1:0] px_out,
    output logic [OPERAND_W-1:0] py_out,
    output logic                 irq
);

    state_t      state_q, state_d;
    logic        ecc1Sticky_q, ecc1Sticky_d;
    logic        ecc2Sticky_q, ecc2Sticky_d;
    logic        desDonePrev_q;
    logic [31:0] readdata_q, readdata_d;
    logic        readdatavalid_q;

    logic [ADDR_W-1:0] region;
    logic [2:0]        wordSel;
    logic              ctrlWrite, statusRead, operandWriteOk;
    logic              kWrEn, pxWrEn, pyWrEn;
    logic [31:0]       kRd, pxRd, pyRd, statusWord;
    logic              busy, desDoneRise, ecc1Set, ecc2Set;

    assign region  = avs_address >> 3;
    assign wordSel = avs_address[2:0];

    assign ctrlWrite  = avs_write && (region == ADDR_W'(REGION_CTRL)) && (wordSel == WORD_CTRL);
    assign statusRead = avs_read  && (region == ADDR_W'(REGION_CTRL)) && (wordSel == WORD_STATUS);

    // Operands are frozen while the controller may be consuming them.
    assign operandWriteOk = avs_write && (state_q == IDLE);
    assign kWrEn  = operandWriteOk && (region == ADDR_W'(REGION_K));
    assign pxWrEn = operandWriteOk && (region == ADDR_W'(REGION_PX));
    assign pyWrEn = operandWriteOk && (region == ADDR_W'(REGION_PY));

    word_reg164 u_k (
        .clk(clk), .n_rst(n_rst), .wr_en_i(kWrEn), .wr_word_i(wordSel),
        .wr_data_i(avs_writedata), .rd_word_i(wordSel), .value_o(k_out), .rd_data_o(kRd)
    );

    word_reg164 u_px (
        .clk(clk), .n_rst(n_rst), .wr_en_i(pxWrEn), .wr_word_i(wordSel),
        .wr_data_i(avs_writedata), .rd_word_i(wordSel), .value_o(px_out), .rd_data_o(pxRd)
    );

    word_reg164 u_py (
        .clk(clk), .n_rst(n_rst), .wr_en_i(pyWrEn), .wr_word_i(wordSel),
        .wr_data_i(avs_writedata), .rd_word_i(wordSel), .value_o(py_out), .rd_data_o(pyRd)
    );

    assign busy       = (state_q != IDLE);
    assign statusWord = {28'b0, busy, des_done, ecc2Sticky_q, ecc1Sticky_q};

    // Only a fresh rising edge ends a DES run, so a done level left high
    // from a previous run cannot complete the next one.
    assign desDoneRise = des_done && !desDonePrev_q;

    assign ecc1Set = (state_q == E1_WAIT) && ecc1_done;
    assign ecc2Set = (state_q == E2_WAIT) && ecc2_done;

    // Read mux; readdata is registered, so a write in the same cycle is
    // not yet visible and the read returns the previous contents.
    always_comb begin
        readdata_d = readdata_q;
        if (avs_read) begin
            readdata_d = '0;
            if (region == ADDR_W'(REGION_CTRL)) begin
                if (wordSel == WORD_STATUS) readdata_d = statusWord;
            end else if (region == ADDR_W'(REGION_K)) begin
                readdata_d = kRd;
            end else if (region == ADDR_W'(REGION_PX)) begin
                readdata_d = pxRd;
            end else if (region == ADDR_W'(REGION_PY)) begin
                readdata_d = pyRd;
            end else if (region == ADDR_W'(REGION_PUX)) begin
                readdata_d = selectWord(PuX, wordSel);
            end else if (region == ADDR_W'(REGION_PUY)) begin
                readdata_d = selectWord(PuY, wordSel);
            end
        end
    end

    // A completion in the same cycle as a clearing STATUS read must survive.
    always_comb begin
        ecc1Sticky_d = ecc1Set || (ecc1Sticky_q && !statusRead);
        ecc2Sticky_d = ecc2Set || (ecc2Sticky_q && !statusRead);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ctrlWrite) begin
                    if (avs_writedata[CTRL_ECC1])      state_d = E1_GO;
                    else if (avs_writedata[CTRL_ECC2]) state_d = E2_GO;
                    else if (avs_writedata[CTRL_DES])  state_d = DES_RUN;
                end
            end
            E1_GO:    state_d = E1_WAIT;
            E1_WAIT:  if (ecc1_done) state_d = IDLE;
            E2_GO:    state_d = E2_WAIT;
            E2_WAIT:  if (ecc2_done) state_d = IDLE;
            DES_RUN:  if (ctrlWrite && avs_writedata[CTRL_DES_STOP]) state_d = DES_WAIT;
            DES_WAIT: if (desDoneRise) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            ecc1Sticky_q    <= 1'b0;
            ecc2Sticky_q    <= 1'b0;
            desDonePrev_q   <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ecc1Sticky_q    <= ecc1Sticky_d;
            ecc2Sticky_q    <= ecc2Sticky_d;
            desDonePrev_q   <= des_done;
            readdata_q      <= readdata_d;
            readdatavalid_q <= avs_read;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign ecc_start1        = (state_q == E1_GO);
    assign ecc_start2        = (state_q == E2_GO);
    assign des_start         = (state_q == DES_RUN);
    assign irq               = ecc1Sticky_q || ecc2Sticky_q;

endmodule

// File: tb/tb_eccdes_host_if.sv
// ---------------------------------------------------------------------------
// tb_eccdes_host_if
// Directed bench for eccdes_host_if: operand assembly and readback, ECC
// start/done sequencing with sticky status and irq, DES handshake with
// edge-qualified done, asynchronous reset mid-run and unmapped accesses.
// ---------------------------------------------------------------------------
module tb_eccdes_host_if;

    logic         clk;
    logic         n_rst;
    logic [5:0]   avs_address;
    logic         avs_write;
    logic         avs_read;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic         ecc_start1, ecc_start2, des_start;
    logic         ecc1_done, ecc2_done, des_done;
    logic [163:0] PuX, PuY;
    logic [163:0] k_out, px_out, py_out;
    logic         irq;

    int assertCount = 0;
    int failCount   = 0;

    int start1Count = 0;
    int start2Count = 0;
    int desCount    = 0;

    logic [163:0] kExp, pxExp, pyExp;
    logic [31:0]  rd;
    int           start1Base, start2Base, desBase;

    eccdes_host_if #(.ADDR_W(6)) dut (
        .clk(clk), .n_rst(n_rst),
        .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .ecc_start1(ecc_start1), .ecc_start2(ecc_start2), .des_start(des_start),
        .ecc1_done(ecc1_done), .ecc2_done(ecc2_done), .des_done(des_done),
        .PuX(PuX), .PuY(PuY),
        .k_out(k_out), .px_out(px_out), .py_out(py_out),
        .irq(irq)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles each start output is seen high, sampled mid-cycle
    always @(negedge clk) begin
        if (ecc_start1) start1Count++;
        if (ecc_start2) start2Count++;
        if (des_start)  desCount++;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [163:0] observed,
                               input logic [163:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // One host write cycle, returns at the falling edge after capture
    task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    // One host read; data must be qualified one cycle after the strobe
    task automatic hostRead(input logic [5:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        checkOutput("readdatavalid", 164'(avs_readdatavalid), 164'd1);
        data = avs_readdata;
    endtask

    task automatic snapshotCounts();
        #1;
        start1Base = start1Count;
        start2Base = start2Count;
        desBase    = desCount;
    endtask

    initial begin
        n_rst         = 1'b1;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        avs_writedata = '0;
        ecc1_done     = 1'b0;
        ecc2_done     = 1'b0;
        des_done      = 1'b0;
        PuX = {4'h9, 32'hE5E5E5E5, 32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1};
        PuY = {4'h6, 32'h55555555, 32'h44440000, 32'h33330000, 32'h22220000, 32'h11110000};

        // Reset state
        #3 n_rst = 1'b0;
        @(negedge clk);
        checkOutput("rst ecc_start1", 164'(ecc_start1), 164'd0);
        checkOutput("rst des_start", 164'(des_start), 164'd0);
        checkOutput("rst irq", 164'(irq), 164'd0);
        checkOutput("rst readdatavalid", 164'(avs_readdatavalid), 164'd0);
        checkOutput("rst k_out", k_out, 164'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Operand k assembly; upper bits of word 5 are dropped
        applyStimulus(6'h08, 32'h11111111);
        applyStimulus(6'h09, 32'h22222222);
        applyStimulus(6'h0A, 32'h33333333);
        applyStimulus(6'h0B, 32'h44444444);
        applyStimulus(6'h0C, 32'h00000005);
        applyStimulus(6'h0D, 32'hFFFFFFFF);
        kExp = {4'hF, 32'h00000005, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        checkOutput("k_out assembled", k_out, kExp);
        hostRead(6'h0D, rd);
        checkOutput("k word5 readback", 164'(rd), 164'h0000000F);
        hostRead(6'h0A, rd);
        checkOutput("k word2 readback", 164'(rd), 164'h33333333);

        // px and py patterns used later
        for (int i = 0; i < 5; i++) applyStimulus(6'h10 + 6'(i), 32'hA5A5A5A5);
        applyStimulus(6'h15, 32'h00000003);
        pxExp = {4'h3, {5{32'hA5A5A5A5}}};
        checkOutput("px_out assembled", px_out, pxExp);
        applyStimulus(6'h1A, 32'h12345678);
        pyExp = 164'h12345678 << 64;
        checkOutput("py_out word2", py_out, pyExp);

        // Read and write in the same cycle: read sees the old value
        @(negedge clk);
        avs_address   = 6'h08;
        avs_writedata = 32'hCAFEF00D;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        checkOutput("rw same cycle valid", 164'(avs_readdatavalid), 164'd1);
        checkOutput("rw same cycle old data", 164'(avs_readdata), 164'h11111111);
        kExp[31:0] = 32'hCAFEF00D;
        hostRead(6'h08, rd);
        checkOutput("rw new data", 164'(rd), 164'hCAFEF00D);

        // ECC phase 1: one-cycle start, done after 40 cycles, sticky status
        snapshotCounts();
        applyStimulus(6'h00, 32'h1);
        checkOutput("ecc1 start high", 164'(ecc_start1), 164'd1);
        @(negedge clk);
        checkOutput("ecc1 start dropped", 164'(ecc_start1), 164'd0);
        hostRead(6'h01, rd);
        checkOutput("status busy ecc1", 164'(rd), 164'h8);
        repeat (35) @(negedge clk);
        ecc1_done = 1'b1;
        @(negedge clk);
        ecc1_done = 1'b0;
        #1;
        checkOutput("ecc1 start pulse count", 164'(start1Count - start1Base), 164'd1);
        checkOutput("irq after ecc1", 164'(irq), 164'd1);
        hostRead(6'h01, rd);
        checkOutput("status ecc1 sticky", 164'(rd), 164'h1);
        hostRead(6'h01, rd);
        checkOutput("status cleared", 164'(rd), 164'h0);
        checkOutput("irq cleared", 164'(irq), 164'd0);

        // CTRL=7: phase 1 has priority; operand writes locked while busy
        snapshotCounts();
        applyStimulus(6'h00, 32'h7);
        checkOutput("ctrl7 start1", 164'(ecc_start1), 164'd1);
        checkOutput("ctrl7 start2", 164'(ecc_start2), 164'd0);
        checkOutput("ctrl7 des_start", 164'(des_start), 164'd0);
        applyStimulus(6'h10, 32'hDEADBEEF);
        checkOutput("px locked", px_out, pxExp);
        ecc1_done = 1'b1;
        @(negedge clk);
        ecc1_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("ctrl7 start1 count", 164'(start1Count - start1Base), 164'd1);
        checkOutput("ctrl7 start2 count", 164'(start2Count - start2Base), 164'd0);
        checkOutput("ctrl7 des count", 164'(desCount - desBase), 164'd0);
        hostRead(6'h01, rd);
        checkOutput("ctrl7 status", 164'(rd), 164'h1);

        // ECC phase 2
        applyStimulus(6'h00, 32'h2);
        checkOutput("ecc2 start high", 164'(ecc_start2), 164'd1);
        checkOutput("ecc2 no start1", 164'(ecc_start1), 164'd0);
        @(negedge clk);
        checkOutput("ecc2 start dropped", 164'(ecc_start2), 164'd0);
        ecc2_done = 1'b1;
        @(negedge clk);
        ecc2_done = 1'b0;
        hostRead(6'h01, rd);
        checkOutput("status ecc2 sticky", 164'(rd), 164'h2);

        // DES with a stale high done level
        des_done = 1'b1;
        applyStimulus(6'h00, 32'h4);
        checkOutput("des_start high", 164'(des_start), 164'd1);
        repeat (3) @(negedge clk);
        checkOutput("des_start held", 164'(des_start), 164'd1);
        hostRead(6'h01, rd);
        checkOutput("status des run", 164'(rd), 164'hC);
        applyStimulus(6'h00, 32'h8);
        checkOutput("des_start low in wait", 164'(des_start), 164'd0);
        repeat (5) @(negedge clk);
        hostRead(6'h01, rd);
        checkOutput("busy with stale done", 164'(rd & 32'h8), 164'h8);
        des_done = 1'b0;
        repeat (3) @(negedge clk);
        hostRead(6'h01, rd);
        checkOutput("busy done low", 164'(rd & 32'h8), 164'h8);
        des_done = 1'b1;
        @(negedge clk);
        hostRead(6'h01, rd);
        checkOutput("des finished", 164'(rd), 164'h4);
        des_done = 1'b0;

        // Public key readback and unmapped locations
        hostRead(6'h20, rd);
        checkOutput("PuX word0", 164'(rd), 164'hA1A1A1A1);
        hostRead(6'h25, rd);
        checkOutput("PuX word5", 164'(rd), 164'h9);
        hostRead(6'h2B, rd);
        checkOutput("PuY word3", 164'(rd), 164'h44440000);
        applyStimulus(6'h3F, 32'hFFFFFFFF);
        hostRead(6'h3F, rd);
        checkOutput("unmapped 0x3F", 164'(rd), 164'h0);
        @(negedge clk);
        checkOutput("valid single cycle", 164'(avs_readdatavalid), 164'd0);
        hostRead(6'h0E, rd);
        checkOutput("unmapped 0x0E", 164'(rd), 164'h0);
        checkOutput("k intact", k_out, kExp);

        // Asynchronous reset in the middle of a DES run
        applyStimulus(6'h00, 32'h4);
        checkOutput("des run before reset", 164'(des_start), 164'd1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        checkOutput("reset des_start", 164'(des_start), 164'd0);
        checkOutput("reset k_out", k_out, 164'd0);
        checkOutput("reset px_out", px_out, 164'd0);
        checkOutput("reset py_out", py_out, 164'd0);
        @(negedge clk);
        n_rst = 1'b1;
        hostRead(6'h01, rd);
        checkOutput("status after reset", 164'(rd), 164'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
